uart_tx_ext: RTL
================

UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 Parameter CLK_FREQ, default 1000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8: payload width; legal range 5..9.
REQ-004 Parameter PARITY, default PARITY_NONE: one of PARITY_NONE, PARITY_EVEN, PARITY_ODD.
REQ-005 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port tx_valid, input, 1: a frame is offered on tx_data.
REQ-009 Port tx_ready, output, 1: the block can accept a frame this cycle.
REQ-010 Port tx_data, input, DATA_BITS: payload, sent LSB first.
REQ-011 Port tx, output, 1: serial line, registered, idle high.
REQ-012 Port tx_busy, output, 1: a frame is in progress.
REQ-013 Port tx_done, output, 1: one-cycle pulse on frame completion.

Function
REQ-014 DIV = CLK_FREQ/BAUD_RATE (integer division) SHALL hold every bit on tx for exactly DIV clk cycles; DIV < 2 or an illegal parameter value SHALL fail elaboration.
REQ-015 Bit timing SHALL use a clock-enable counter in the clk domain; no derived or gated clocks.
REQ-016 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal not tx_ready.
REQ-018 Acceptance SHALL occur on a rising edge sampling tx_valid=1 and tx_ready=1; at that edge tx_data is captured, the divider restarts at 0, tx goes 0 and the state becomes START.
REQ-019 tx_valid while busy SHALL be ignored and not queued; tx_data changes after acceptance SHALL not affect the frame.
REQ-020 START lasts DIV cycles, then DATA sends DATA_BITS bits LSB first, DIV cycles each.
REQ-021 When PARITY is not PARITY_NONE, PARITY SHALL send one bit: EVEN = XOR of the captured payload; ODD = its inverse; otherwise the PARITY state is skipped.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS*DIV cycles, then return to IDLE with tx_done=1 for exactly that first IDLE cycle.
REQ-023 Frame length from the acceptance edge to the tx_done cycle SHALL be (1+DATA_BITS+P+STOP_BITS)*DIV cycles, where P = 1 with parity and 0 without.
REQ-024 With tx_valid held high, the next frame SHALL be accepted on the tx_done cycle, giving exactly one idle-high cycle between frames.

Reset
REQ-025 While rst=1 at an edge: state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, divider and bit counter at 0.
REQ-026 Reset mid-frame SHALL abort the frame with no tx_done pulse; tx SHALL be 1 from the next cycle.
REQ-027 rst SHALL take priority over a simultaneous handshake.

Structure
REQ-028 Package uart_pkg SHALL hold the parity enum (PARITY_NONE/EVEN/ODD) and the tx state enum typedef.
REQ-029 Sub-module uart_baud_gen SHALL provide the DIV counter with a synchronous restart input and a one-cycle bit_tick output.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000, DIV=10)
REQ-030 8N1, send 0xA5: tx = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; tx_done pulses 100 cycles after acceptance.
REQ-031 8E1 with 0x07: parity bit 1; 8O1 with 0x07: parity bit 0; frame length 110 cycles.
REQ-032 DATA_BITS=7, STOP_BITS=2, send 0x55: 7 data bits 1,0,1,0,1,0,1; stop high for 20 cycles; frame length 100 cycles.
REQ-033 tx_valid held with 0x00 then 0xFF: exactly one idle-high cycle between the last stop bit and the second start bit; two tx_done pulses.
REQ-034 Assert rst during data bit 3: tx=1 next cycle, tx_ready=1, no tx_done pulse; a new 0x3C frame afterwards is correct.
REQ-035 Pulse tx_valid with 0xFF mid-frame and change tx_data: the line carries only the original frame; 0xFF is never sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity selection and the TX state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // A zero baud rate yields 0 so the elaboration guard reports it instead of dividing by zero.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    if (baud_rate <= 0) return 0;
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_bit_tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || i_restart || !i_en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_tick = i_en && w_wrap;

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with configurable payload width, parity and stop bits; one frame in flight.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 1000000,
  parameter int      BAUD_RATE = 9600,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BCNT_W = 4;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_ext: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_ext: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_ext: STOP_BITS must be 1 or 2");
  end
  if (!(PARITY inside {PARITY_NONE, PARITY_EVEN, PARITY_ODD})) begin : g_bad_par
    $error("uart_tx_ext: illegal PARITY value");
  end

  tx_state_e           r_state;
  tx_state_e           w_state_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                r_par;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic [BCNT_W-1:0]   w_bit_cnt_nxt;
  logic                r_tx;
  logic                w_tx_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_load;
  logic                w_shift;
  logic                w_tick;
  logic                w_active;

  assign w_active = (r_state != ST_IDLE);

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_active),
    .i_restart  (w_load),
    .o_bit_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Payload and parity are captured once at acceptance, so later tx_data changes cannot leak in.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= tx_data;
      r_par  <= (^tx_data) ^ (PARITY == PARITY_ODD);
    end else if (w_shift) begin
      r_data <= r_data >> 1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_valid) begin
          w_load        = 1'b1;
          w_state_nxt   = ST_START;
          w_tx_nxt      = 1'b0;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_tx_nxt      = r_data[0];
          w_shift       = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BCNT_W'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            if (PARITY != PARITY_NONE) begin
              w_state_nxt = ST_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = ST_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_tx_nxt      = r_data[0];
            w_shift       = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt   = ST_STOP;
          w_tx_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          if (r_bit_cnt == BCNT_W'(STOP_BITS - 1)) begin
            w_state_nxt   = ST_IDLE;
            w_done_nxt    = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_tx_nxt      = 1'b1;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  assign tx_ready = (r_state == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx       = r_tx;
  assign tx_done  = r_done;

endmodule
